// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry valid/ready pipeline register with a skid slot. The head entry
// lives in the main register, which drives out_data straight from the flop.
// A second entry is parked in the skid register while downstream stalls.
// in_ready and out_valid are registered and depend only on the occupancy
// state, so there is no combinational path from out_ready or in_valid to
// in_ready. This allows chaining without building long ready paths.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no entry held; in_ready=1, out_valid=0, count=0
// BUSY  | one entry in main; in_ready=1, out_valid=1, count=1
// FULL  | main holds head, skid holds next; in_ready=0, out_valid=1,
//       | count=2
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (highest priority)
//   flush     : synchronous discard of all held entries
//   in_valid  : upstream presents in_data
//   in_ready  : stage can accept this cycle
//   in_data   : upstream payload
//   out_valid : out_data holds a valid entry
//   out_ready : downstream accepts this cycle
//   out_data  : head-entry payload (main register)
//   count     : occupancy, 0..2
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Encoding equals occupancy, so count is a copy of the next state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // No mux after the flop: the head entry is always in main.
    assign out_data = main_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid_in = 1'b1;
                    state_nxt    = FULL;
                end else if (out_fire) begin
                    // main keeps its stale value; out_valid masks it.
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // Reset and flush have the same effect; both override any
            // same-cycle handshake, so a flushed in_fire is dropped.
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            count     <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    // Scoreboard: accepted entries in acceptance order.
    logic [31:0] sb[$];

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and update the scoreboard from the
    // bench's own view of occupancy; outputs are sampled 1 time unit
    // after the edge.
    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] id, input logic ordy);
        bit m_in_fire;
        bit m_out_fire;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        m_out_fire = (sb.size() > 0) && ordy;
        m_in_fire  = iv && (sb.size() < 2);
        @(posedge clk);
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (m_out_fire) void'(sb.pop_front());
            if (m_in_fire) sb.push_back(id);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 32'h0, 0);
        drive(1, 0, 1, 32'hDEAD_BEEF, 1);
        drive(0, 0, 0, 32'h0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (count !== 2'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++; $display("FAIL reset_out_data got %h want 0", out_data);
        end
    endtask

    task automatic test_single();
        drive(0, 0, 1, 32'hA5, 1);
        checks++;
        if (out_valid !== 1'b1 || count !== 2'd1) begin
            errors++;
            $display("FAIL single_valid got v=%b c=%0d want v=1 c=1", out_valid, count);
        end
        checks++;
        if (sb.size() != 1 || out_data !== sb[0] || out_data !== 32'hA5) begin
            errors++; $display("FAIL single_data got %h want a5", out_data);
        end
        drive(0, 0, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL single_drain got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_seq[2];
        exp_seq[0] = 32'h11;
        exp_seq[1] = 32'h22;
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got c=%0d r=%b want c=2 r=0", count, in_ready);
        end
        drive(0, 0, 1, 32'h33, 0);
        checks++;
        if (count !== 2'd2 || out_data !== 32'h11) begin
            errors++;
            $display("FAIL fill_reject got c=%0d d=%h want c=2 d=11", count, out_data);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0 || out_data !== sb[0] ||
                out_data !== exp_seq[i]) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, exp_seq[i]);
            end
            drive(0, 0, 0, 32'h0, 1);
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 32'(i), 1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || sb.size() == 0 ||
                out_data !== sb[0] || count !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] got v=%b d=%h c=%0d r=%b want v=1 d=%h c=1 r=1",
                         i, out_valid, out_data, count, in_ready, i);
            end
        end
        drive(0, 0, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL b2b_drain got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_flush();
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(0, 1, 1, 32'h44, 0);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 32'h0) begin
            errors++;
            $display("FAIL flush_state got c=%0d v=%b r=%b d=%h want c=0 v=0 r=1 d=0",
                     count, out_valid, in_ready, out_data);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 32'h0, 1);
            checks++;
            if (out_valid !== 1'b0 || out_data === 32'h44) begin
                errors++;
                $display("FAIL flush_dropped[%0d] got v=%b d=%h want v=0", k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_over_flush();
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(1, 1, 0, 32'h0, 1);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 32'h0 || dut.skid_q !== 32'h0) begin
            errors++;
            $display("FAIL rst_full got c=%0d v=%b r=%b main=%h skid=%h want 0 0 1 0 0",
                     count, out_valid, in_ready, out_data, dut.skid_q);
        end
        drive(0, 0, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL rst_no_emit got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_random();
        int cyc_err = 0;
        for (int n = 0; n < 10000; n++) begin
            checks++;
            if (count !== 2'(sb.size()) || out_valid !== (sb.size() != 0) ||
                in_ready !== (sb.size() < 2) ||
                (sb.size() != 0 && out_data !== sb[0])) begin
                errors++;
                if (cyc_err < 20)
                    $display("FAIL rand[%0d] got c=%0d v=%b r=%b d=%h want c=%0d head=%h",
                             n, count, out_valid, in_ready, out_data, sb.size(),
                             (sb.size() != 0) ? sb[0] : 32'h0);
                cyc_err++;
            end
            drive(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 32'h0, 1);
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL rand_drain got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_reset_over_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only at posedge clk.
REQ-004 flush  input  1  synchronous discard of all held entries; pipeline redirect.
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data holds a valid entry.
REQ-009 out_ready  input  1  downstream accepts this cycle.
REQ-010 out_data  output  WIDTH  head-entry payload.
REQ-011 count  output  2  occupancy: 0, 1 or 2 entries.

Function
REQ-012 Two storage registers SHALL exist: main (head, drives out_data) and skid (second entry).
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-014 States SHALL be EMPTY (count=0), BUSY (count=1) and FULL (count=2).
REQ-015 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL, and SHALL be decoded from state only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL be 1 in BUSY and FULL, and SHALL be decoded from state only.
REQ-017 out_data SHALL equal the main register directly, with no mux after the flop.
REQ-018 EMPTY with in_fire: main<=in_data, next state BUSY; otherwise remain EMPTY.
REQ-019 BUSY with in_fire and out_fire: main<=in_data, remain BUSY.
REQ-020 BUSY with in_fire and no out_fire: skid<=in_data, next state FULL.
REQ-021 BUSY with out_fire and no in_fire: next state EMPTY; main holds its stale value.
REQ-022 BUSY with neither in_fire nor out_fire: hold.
REQ-023 FULL with out_fire: main<=skid, next state BUSY; in_fire cannot occur because in_ready=0.
REQ-024 FULL with no out_fire: hold main and skid unchanged.
REQ-025 Latency: data accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when entering from EMPTY.
REQ-026 Entries SHALL leave in acceptance order; no entry is lost or duplicated.
REQ-027 Throughput: with in_valid=1 and out_ready=1 held continuously, one entry SHALL transfer per cycle after the first.
REQ-028 flush=1 SHALL override all transitions: next state EMPTY, main<=0, skid<=0, and any same-cycle in_fire or out_fire is discarded from storage.
REQ-029 Upstream SHALL NOT treat an in_fire in a flush cycle as lost-and-retry: the flushed entry is dropped by design.
REQ-030 While out_valid=0 after a drain, out_data is stale and is not checked.

Reset
REQ-031 reset=1 at posedge clk SHALL force state EMPTY, main=0, skid=0, count=0, in_ready=1 and out_valid=0 in the following cycle.
REQ-032 reset SHALL take priority over flush and over all handshakes, including reset asserted mid-operation in FULL.
REQ-033 Before the first posedge clk with reset=1, outputs are undefined.

Verification
REQ-034 Reset, then in_valid=1 with in_data=0xA5 for 1 cycle and out_ready=1 -> next cycle out_valid=1, out_data=0xA5, count=1; following cycle out_valid=0, count=0.
REQ-035 out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0; a third in_valid with 0x33 is not accepted; release out_ready -> outputs 0x11, then 0x22, then out_valid=0.
REQ-036 in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-037 In FULL (0x11, 0x22), assert flush with in_valid=1 and in_data=0x44 -> next cycle count=0, out_valid=0, in_ready=1, out_data=0; 0x44 never appears.
REQ-038 In FULL, assert reset and flush together with out_ready=1 -> next cycle EMPTY, main=0 and skid=0, and no entry is emitted.
REQ-039 Random in_valid/out_ready, flush-free, 10k cycles -> scoreboard shows in-order, lossless, duplicate-free delivery, and count always equals accepted minus delivered.
